// File: rtl/divisor_programavel.sv
// Programmable tick generator: fixed display tick plus a reloadable
// main tick and a 50% square output, all as clock-enable pulses.
module divisor_programavel #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DISPLAY_DIV = 78125,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  output logic             display_tick,
  output logic             tick,
  output logic             clock_out,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pending,
  output logic             div_error
);

  localparam int unsigned DW =
    (DISPLAY_DIV > 1) ? $clog2(DISPLAY_DIV) : 1;
  localparam logic [DW-1:0] DLAST =
    DW'(DISPLAY_DIV - 1);
  localparam logic [WIDTH-1:0] DEF =
    WIDTH'(DEFAULT_DIV);

  logic [DW-1:0]    dcnt;
  logic [WIDTH-1:0] pend_val;
  logic [WIDTH-1:0] last;
  logic             term;
  logic             dterm;
  logic             ld_ok;
  logic             ld_bad;

  // div_active is never zero, so this cannot underflow
  assign last   = div_active - WIDTH'(1);
  assign term   = enable && (count == last);
  assign dterm  = enable && (dcnt == DLAST);
  assign ld_ok  = div_load && (div_value != '0);
  assign ld_bad = div_load && (div_value == '0);

  // Main counter: wrap on the terminal edge, tick and toggle there
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      tick      <= 1'b0;
      clock_out <= 1'b0;
    end else begin
      tick <= term;
      if (enable) begin
        if (term) begin
          count     <= '0;
          clock_out <= ~clock_out;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

  // Display counter: free-running on enable, independent of main
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dcnt         <= '0;
      display_tick <= 1'b0;
    end else begin
      display_tick <= dterm;
      if (enable) begin
        if (dterm) begin
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
    end
  end

  // Divisor reload: stage in pending, swap only at a wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_active  <= DEF;
      pend_val    <= DEF;
      div_pending <= 1'b0;
      div_error   <= 1'b0;
    end else begin
      div_error <= ld_bad;
      if (term && ld_ok) begin
        div_active  <= div_value;
        div_pending <= 1'b0;
      end else if (term && div_pending) begin
        div_active  <= pend_val;
        div_pending <= 1'b0;
      end else if (ld_ok) begin
        pend_val    <= div_value;
        div_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_divisor_programavel.sv
// Bench for divisor_programavel: directed plan cases plus random
// traffic, checked each cycle against an event-level model.
module tb_divisor_programavel;

  localparam int W  = 8;
  localparam int DD = 5;
  localparam int DF = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] div_value;
  logic         div_load;
  logic         display_tick;
  logic         tick;
  logic         clock_out;
  logic [W-1:0] count;
  logic [W-1:0] div_active;
  logic         div_pending;
  logic         div_error;

  int n_tests = 0;
  int n_fail  = 0;

  int m_phase;
  int m_div;
  int m_dcnt;
  int m_pend[$];
  bit m_tick;
  bit m_dtick;
  bit m_clk;
  bit m_err;

  divisor_programavel #(
    .WIDTH(W),
    .DISPLAY_DIV(DD),
    .DEFAULT_DIV(DF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .div_value(div_value),
    .div_load(div_load),
    .display_tick(display_tick),
    .tick(tick),
    .clock_out(clock_out),
    .count(count),
    .div_active(div_active),
    .div_pending(div_pending),
    .div_error(div_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_div   = DF;
    m_dcnt  = 0;
    m_pend.delete();
    m_tick  = 0;
    m_dtick = 0;
    m_clk   = 0;
    m_err   = 0;
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(m_phase));
    chk("div_active", 32'(div_active), 32'(m_div));
    chk("div_pending", 32'(div_pending),
        32'(m_pend.size() != 0));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("display_tick", 32'(display_tick), 32'(m_dtick));
    chk("clock_out", 32'(clock_out), 32'(m_clk));
    chk("div_error", 32'(div_error), 32'(m_err));
  endtask

  // One rule-level step: a period ends after m_div enabled cycles
  task automatic model_edge(input bit en, input bit ld,
                            input int v);
    bit applied;
    applied = 0;
    m_err   = ld && (v == 0);
    m_tick  = 0;
    m_dtick = 0;
    if (en) begin
      m_dcnt++;
      m_dtick = (m_dcnt % DD) == 0;
      if (m_phase + 1 == m_div) begin
        m_tick  = 1;
        m_clk   = !m_clk;
        m_phase = 0;
        if (ld && v != 0) begin
          m_div = v;
          m_pend.delete();
          applied = 1;
        end else if (m_pend.size() != 0) begin
          m_div = m_pend.pop_front();
        end
      end else begin
        m_phase++;
      end
    end
    if (ld && v != 0 && !applied) begin
      m_pend.delete();
      m_pend.push_back(v);
    end
  endtask

  task automatic step(input bit en, input bit ld, input int v);
    enable    = en;
    div_load  = ld;
    div_value = v[W-1:0];
    @(posedge clock);
    model_edge(en, ld, v);
    #1;
    check_all();
    @(negedge clock);
    div_load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic goto_phase(input int p);
    for (int k = 0; k < 300 && m_phase != p; k++) step(1, 0, 0);
    chk("goto_phase", 32'(m_phase), 32'(p));
  endtask

  task automatic do_reset();
    div_load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_div_active", 32'(div_active), DF);
    chk("rst_pending", 32'(div_pending), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_dtick", 32'(display_tick), 0);
    chk("rst_clock_out", 32'(clock_out), 0);
    chk("rst_error", 32'(div_error), 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    model_reset();
    #3;
    check_all();
    @(negedge clock);
    reset = 1'b0;

    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 0);
      chk("plan_tick", 32'(tick), 32'(i % 8 == 0));
      chk("plan_dtick", 32'(display_tick), 32'(i % 5 == 0));
      chk("plan_clkout", 32'(clock_out), 32'((i / 8) % 2));
    end

    goto_phase(2);
    step(1, 1, 3);
    chk("pend_after_load", 32'(div_pending), 1);
    run(5);
    chk("div3_applied", 32'(div_active), 3);
    run(12);

    goto_phase(1);
    step(1, 1, 4);
    step(1, 1, 6);
    run(20);
    chk("last_load_wins", 32'(div_active), 6);

    step(1, 1, 8);
    run(20);
    goto_phase(7);
    step(1, 1, 2);
    chk("term_load_now", 32'(div_active), 2);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("term_load_tick", 32'(tick), 1);
    run(6);

    step(1, 1, 0);
    chk("zero_err", 32'(div_error), 1);
    chk("zero_keep_div", 32'(div_active), 2);
    step(1, 0, 0);
    chk("zero_err_clear", 32'(div_error), 0);

    step(1, 1, 1);
    run(4);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      chk("div1_tick", 32'(tick), 1);
    end
    step(0, 1, 5);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      chk("dis_tick", 32'(tick), 0);
    end
    run(3);
    goto_phase(4);
    do_reset();
    run(10);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) != 0,
             $urandom_range(0, 9) == 0,
             int'($urandom_range(0, 12)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divisor_programavel.md
# divisor_programavel

Programmable single-clock-domain tick generator for the irrigation controller. It replaces ripple-clock divider chains with clock-enable pulses derived from the system clock. It provides a fixed-rate display tick, and a main tick whose divisor can be reloaded at run time without glitches. It also provides a 50%-duty square output for legacy consumers.

## Interface
- WIDTH, 32: width of the main divisor and counter.
- DISPLAY_DIV, 78125: fixed divisor for display_tick; must be ≥1.
- DEFAULT_DIV, 50000000: main divisor after reset; must be ≥1 and < 2^WIDTH.
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, both counters advance; when low, they freeze.
- div_value  in  WIDTH  new main divisor; sampled when div_load is high.
- div_load  in  1  one-cycle request to load div_value.
- display_tick  out  1  one-cycle pulse every DISPLAY_DIV enabled cycles.
- tick  out  1  one-cycle pulse every active-divisor enabled cycles.
- clock_out  out  1  square wave that toggles on every tick; period is 2×divisor.
- count  out  WIDTH  current main counter value.
- div_active  out  WIDTH  divisor currently in use.
- div_pending  out  1  a loaded divisor is waiting to take effect.
- div_error  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset values: count=0, display counter=0, div_active=DEFAULT_DIV, div_pending=0, tick=0, display_tick=0, clock_out=0, div_error=0.
- Main counter behaviour when enable=1:
  - If count == div_active−1, count wraps to 0 on that edge.
  - Otherwise count increments by 1.
- Wrap edge ("terminal edge"):
  - tick=1 for exactly the following cycle.
  - clock_out toggles.
  - If div_pending=1, div_active takes the pending value and div_pending clears.
- Display counter:
  - Independent of the main counter; counts 0..DISPLAY_DIV−1 on enable.
  - Wrap gives display_tick=1 for exactly one cycle.
- Divisor = 1: tick stays high every enabled cycle, and clock_out toggles every enabled cycle. The same applies to display_tick when DISPLAY_DIV=1.
- Load with div_value ≥ 1:
  - The value is stored in the pending register and div_pending=1 on the next edge.
  - A later load before application overwrites the pending value; the last value wins.
- Load with div_value = 0: ignored. div_error pulses for one cycle, and pending state is unchanged.
- Load on the same edge as a terminal edge: the new value is applied on that edge, and the next period uses it.
- Load while enable=0: the value is accepted into pending and applied at the first terminal edge after enable returns.
- enable=0:
  - Counters, clock_out and div_active hold.
  - tick and display_tick are 0.
  - Loads are still accepted.
- No load ever truncates or extends the current period. Changes take effect only at a wrap, so there are no runt pulses on clock_out.
- Width rules:
  - Compare against div_active−1 computed in WIDTH bits. div_active is never 0, so there is no underflow.
  - DISPLAY_DIV counter width = clog2(DISPLAY_DIV), minimum 1.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- From reset deassertion with enable=1: the first tick is high in the cycle after the DEFAULT_DIV-th rising edge. Ticks then repeat every div_active cycles.
- div_load to div_pending=1: 1 cycle.
- div_load to div_error: 1 cycle.
- The new divisor is visible on div_active at the first terminal edge at or after the load edge.
- Asynchronous reset mid-period:
  - All outputs return to their reset values immediately.
  - Any pending divisor is discarded.
  - div_active returns to DEFAULT_DIV.

## Test plan
All cases use simulation parameters WIDTH=8, DISPLAY_DIV=5, DEFAULT_DIV=8.
- Reset release with enable=1 for 40 cycles:
  - tick at cycles 8, 16, 24, 32, 40.
  - display_tick at cycles 5, 10, …, 40.
  - clock_out toggles with period 16.
- div_load with div_value=3 at count=2:
  - div_pending=1 one cycle later.
  - Current period completes at 8; the next ticks are 3 cycles apart.
  - div_pending then clears.
- Two loads (4, then 6) inside one period: only 6 is applied, at the next wrap.
- Load on the terminal edge:
  - div_value=2 with div_load high at count=7.
  - The next tick comes 2 cycles later.
- Load with div_value=0: div_error pulses for 1 cycle, and div_active and div_pending are unchanged.
- Divisor 1, then enable low for 5 cycles, then reset mid-period:
  - With divisor 1, tick is high continuously.
  - While enable is low, tick=0 and count and clock_out hold.
  - Reset at count=4 returns all outputs to reset values with div_active=8.
